// File: rtl/circuito_exp5_jogo_pkg.sv
// Shared definitions for the memory game: FSM state codes (as shown on db_estado),
// sequence ROM contents and default timing.
package circuito_exp5_jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIO_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROX_JOGADA   = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_GANHOU    = 4'hA,
    FIM_ERRO      = 4'hD,
    FIM_TIMEOUT   = 4'hE
  } estado_t;

  localparam int unsigned TIMEOUT_DEFAULT = 3000;
  localparam int unsigned SEQ_LEN_DEFAULT = 16;

  function automatic logic [3:0] rom_seq(input logic [3:0] addr);
    logic [3:0] val;
    case (addr)
      4'h0:    val = 4'b0001;
      4'h1:    val = 4'b0010;
      4'h2:    val = 4'b0100;
      4'h3:    val = 4'b1000;
      4'h4:    val = 4'b0100;
      4'h5:    val = 4'b0010;
      4'h6:    val = 4'b0001;
      4'h7:    val = 4'b0001;
      4'h8:    val = 4'b0010;
      4'h9:    val = 4'b0010;
      4'hA:    val = 4'b0100;
      4'hB:    val = 4'b0100;
      4'hC:    val = 4'b1000;
      4'hD:    val = 4'b1000;
      4'hE:    val = 4'b0001;
      default: val = 4'b0100;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/circuito_exp5_jogo_if.sv
// Player-facing signals of the game: start request, buttons and result outputs.
interface circuito_exp5_jogo_if;
  logic       jogar;
  logic [3:0] botoes;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic [3:0] leds;

  modport master (output jogar, botoes, input ganhou, perdeu, pronto, leds);
  modport slave  (input jogar, botoes, output ganhou, perdeu, pronto, leds);
endinterface

// File: rtl/circuito_exp5_jogo_hex7seg.sv
// 4-bit hex digit to active-low 7-segment pattern, bit order g..a.
module circuito_exp5_jogo_hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/circuito_exp5_jogo.sv
// Genius-style memory game: control FSM plus datapath (address/round counters,
// sequence ROM, jogada register, button edge detector, inactivity timer).
module circuito_exp5_jogo
  import circuito_exp5_jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  circuito_exp5_jogo_if.slave  jogo,
  output logic [6:0]           db_contagem,
  output logic [6:0]           db_memoria,
  output logic [6:0]           db_estado,
  output logic [6:0]           db_jogadafeita,
  output logic [6:0]           db_sequencia,
  output logic                 db_clock,
  output logic                 db_iniciar,
  output logic                 db_fimseq,
  output logic                 db_igualseq,
  output logic                 db_igualjogada,
  output logic                 db_igual,
  output logic                 db_tem_jogada,
  output logic                 db_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  estado_t        estado_q, estado_d;
  logic [3:0]     endereco_q, endereco_d;
  logic [3:0]     rodada_q, rodada_d;
  logic [3:0]     jogada_q, jogada_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           tem_jogada_q;

  logic       tem_jogada;
  logic       jogada_pulse;
  logic       timeout;
  logic       igual;
  logic       fimseq;
  logic       igualseq;
  logic [3:0] memoria;

  assign tem_jogada   = |jogo.botoes;
  assign jogada_pulse = tem_jogada & ~tem_jogada_q;
  assign memoria      = rom_seq(endereco_q);
  assign igual        = (jogada_q == memoria);
  assign fimseq       = (rodada_q == 4'(SEQ_LEN - 1));
  assign igualseq     = (endereco_q == rodada_q);
  assign timeout      = (estado_q == ESPERA) && (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= INICIAL;
      endereco_q   <= '0;
      rodada_q     <= '0;
      jogada_q     <= '0;
      timer_q      <= '0;
      tem_jogada_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      endereco_q   <= endereco_d;
      rodada_q     <= rodada_d;
      jogada_q     <= jogada_d;
      timer_q      <= timer_d;
      tem_jogada_q <= tem_jogada;
    end
  end

  // Timer defaults to clear; it only advances while idle in ESPERA.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    timer_d    = '0;
    case (estado_q)
      INICIAL: if (jogo.jogar) estado_d = PREPARA;
      PREPARA: begin
        endereco_d = '0;
        rodada_d   = '0;
        jogada_d   = '0;
        estado_d   = INICIO_RODADA;
      end
      INICIO_RODADA: begin
        endereco_d = '0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        if (jogada_pulse)  estado_d = REGISTRA;
        else if (timeout)  estado_d = FIM_TIMEOUT;
        else               timer_d  = timer_q + 1'b1;
      end
      REGISTRA: begin
        jogada_d = jogo.botoes;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igual)                 estado_d = FIM_ERRO;
        else if (igualseq && fimseq) estado_d = FIM_GANHOU;
        else if (igualseq)          estado_d = PROX_RODADA;
        else                        estado_d = PROX_JOGADA;
      end
      PROX_JOGADA: begin
        endereco_d = endereco_q + 1'b1;
        estado_d   = ESPERA;
      end
      PROX_RODADA: begin
        rodada_d = rodada_q + 1'b1;
        estado_d = INICIO_RODADA;
      end
      FIM_GANHOU, FIM_ERRO, FIM_TIMEOUT: if (jogo.jogar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase
  end

  assign jogo.ganhou = (estado_q == FIM_GANHOU);
  assign jogo.perdeu = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
  assign jogo.pronto = (estado_q == FIM_GANHOU) || (estado_q == FIM_ERRO) ||
                       (estado_q == FIM_TIMEOUT);
  assign jogo.leds   = jogada_q;

  assign db_igual       = igual;
  assign db_igualjogada = igual;
  assign db_clock       = clock;
  assign db_iniciar     = jogo.jogar;
  assign db_fimseq      = fimseq;
  assign db_igualseq    = igualseq;
  assign db_tem_jogada  = tem_jogada;
  assign db_timeout     = timeout;

  circuito_exp5_jogo_hex7seg u_hex_contagem (.hex(endereco_q),      .seg(db_contagem));
  circuito_exp5_jogo_hex7seg u_hex_memoria  (.hex(memoria),         .seg(db_memoria));
  circuito_exp5_jogo_hex7seg u_hex_estado   (.hex(4'(estado_q)),    .seg(db_estado));
  circuito_exp5_jogo_hex7seg u_hex_jogada   (.hex(jogada_q),        .seg(db_jogadafeita));
  circuito_exp5_jogo_hex7seg u_hex_rodada   (.hex(rodada_q),        .seg(db_sequencia));

endmodule

// File: tb/tb_circuito_exp5_jogo.sv
// Randomized bench for the memory game against a round/index game model.
module tb_circuito_exp5_jogo;

  localparam int TIMEOUT = 3000;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;
  logic       db_clock, db_iniciar, db_fimseq, db_igualseq, db_igualjogada;
  logic       db_igual, db_tem_jogada, db_timeout;

  circuito_exp5_jogo_if jif ();

  circuito_exp5_jogo #(.TIMEOUT(TIMEOUT), .SEQ_LEN(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .jogo           (jif),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_sequencia   (db_sequencia),
    .db_clock       (db_clock),
    .db_iniciar     (db_iniciar),
    .db_fimseq      (db_fimseq),
    .db_igualseq    (db_igualseq),
    .db_igualjogada (db_igualjogada),
    .db_igual       (db_igual),
    .db_tem_jogada  (db_tem_jogada),
    .db_timeout     (db_timeout)
  );

  always #5 clock = ~clock;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  int n_cmp = 0;
  int n_err = 0;

  // Game model: current round, index within round, result (0 playing, 1 won, 2 lost)
  int m_r, m_i, m_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [3:0] v);
    if (m_res != 0) return;
    if (v != rom[m_i]) m_res = 2;
    else if (m_i == m_r) begin
      if (m_r == 15) m_res = 1;
      else begin
        m_r++;
        m_i = 0;
      end
    end else m_i++;
  endtask

  task automatic check_game(input logic [3:0] v);
    int code;
    code = (m_res == 0) ? 3 : (m_res == 1) ? 10 : 13;
    check("estado", db_estado, seg(code));
    check("ganhou", jif.ganhou, m_res == 1);
    check("perdeu", jif.perdeu, m_res == 2);
    check("pronto", jif.pronto, m_res != 0);
    check("leds", jif.leds, v);
    check("jogadafeita", db_jogadafeita, seg(v));
    check("sequencia", db_sequencia, seg(m_r));
    check("contagem", db_contagem, seg(m_i));
    check("memoria", db_memoria, seg(rom[m_i]));
    check("igual", db_igual, v == rom[m_i]);
    check("fimseq", db_fimseq, m_r == 15);
    check("igualseq", db_igualseq, m_i == m_r);
  endtask

  task automatic press(input logic [3:0] v);
    int h, rel;
    h   = $urandom_range(3, 10);
    rel = $urandom_range(3, 10);
    jif.botoes = v;
    for (int k = 0; k < h; k++) begin
      jif.jogar = (k < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      if (k == 0) check("tem_jogada", db_tem_jogada, 1'b1);
    end
    jif.jogar  = 1'b0;
    jif.botoes = 4'h0;
    repeat (rel) step();
    apply(v);
    check_game(v);
  endtask

  task automatic start_game();
    jif.jogar = 1'b1;
    repeat (5) step();
    check("iniciar", db_iniciar, 1'b1);
    jif.jogar = 1'b0;
    repeat (2) step();
    m_r = 0; m_i = 0; m_res = 0;
    check("start_estado", db_estado, seg(3));
    check("start_leds", jif.leds, 4'h0);
    check("start_sequencia", db_sequencia, seg(0));
    check("start_contagem", db_contagem, seg(0));
  endtask

  // err_round < 0 plays a perfect game
  task automatic play_game(input int err_round, input int err_idx, input logic [3:0] wrong);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i <= r; i++) begin
        if (r == err_round && i == err_idx) begin
          press(wrong);
          return;
        end
        press(rom[i]);
      end
  endtask

  initial begin
    int n, found, er, ei;
    logic [3:0] wr;

    reset = 1'b1;
    jif.jogar  = 1'b0;
    jif.botoes = 4'h0;
    repeat (3) step();
    reset = 1'b0;
    repeat (15) step();
    check("rst_estado", db_estado, seg(0));
    check("rst_ganhou", jif.ganhou, 1'b0);
    check("rst_perdeu", jif.perdeu, 1'b0);
    check("rst_pronto", jif.pronto, 1'b0);
    check("rst_leds", jif.leds, 4'h0);

    start_game();
    play_game(-1, 0, 4'h0);
    check("win_result", m_res, 1);

    start_game();
    play_game(2, 2, 4'h8);

    start_game();
    er = $urandom_range(0, 15);
    ei = $urandom_range(0, er);
    do wr = 4'($urandom_range(1, 15)); while (wr == rom[ei]);
    play_game(er, ei, wr);

    // Inactivity: jogar seen on one edge from a FIM state, then no buttons
    jif.jogar = 1'b1;
    n = 0;
    found = 0;
    while (n < TIMEOUT + 50 && found == 0) begin
      step();
      n++;
      jif.jogar = 1'b0;
      if (db_timeout) found = 1;
    end
    check("timeout_seen", found, 1);
    check("timeout_cycle", n, TIMEOUT + 2);
    step();
    check("to_pulse_end", db_timeout, 1'b0);
    check("to_estado", db_estado, seg(14));
    check("to_perdeu", jif.perdeu, 1'b1);
    check("to_pronto", jif.pronto, 1'b1);
    check("to_ganhou", jif.ganhou, 1'b0);

    // Reset in the middle of round 1
    start_game();
    press(rom[0]);
    jif.botoes = rom[0];
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_estado", db_estado, seg(0));
    check("mid_rst_leds", jif.leds, 4'h0);
    check("mid_rst_sequencia", db_sequencia, seg(0));
    check("mid_rst_contagem", db_contagem, seg(0));
    jif.botoes = 4'h0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_estado", db_estado, seg(0));
    start_game();
    press(rom[0]);
    press(rom[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
